ifid_queue: RTL
===============

// Module: ifid_queue
// PURPOSE
//  Decoupling FIFO between the fetch stage and the decode stage. Each entry holds one
//  fetch bundle: Instr1, Instr2, PCA and CIA. Fetch pushes one bundle per cycle on
//  pushReq and throttles itself on full. Decode pops with first-word-fall-through reads.
//  A mispredict or redirect clears the queue with FLUSH.
// PARAMETERS
//  DEPTH   8   number of bundle entries; power of 2, >= 2
//  ADDR_W  3   log2(DEPTH); pointer width
//  DATA_W  32  width of each field (Instr1, Instr2, PCA, CIA)
// PORTS
//  CLK          in   1          rising-edge clock
//  RESET        in   1          asynchronous reset, active-low
//  FLUSH        in   1          synchronous clear of all entries
//  pushReq      in   1          fetch offers a bundle this cycle
//  Instr1_in    in   DATA_W     older instruction of the bundle
//  Instr2_in    in   DATA_W     younger instruction (0 = null slot)
//  PCA_in       in   DATA_W     PC-after of the bundle
//  CIA_in       in   DATA_W     current-instruction address of the bundle
//  full         out  1          no free entry; pushes are rejected
//  popReq       in   1          decode consumes the head entry this cycle
//  empty        out  1          no valid entry; head outputs are 0
//  Instr1_out   out  DATA_W     head bundle Instr1
//  Instr2_out   out  DATA_W     head bundle Instr2
//  PCA_out      out  DATA_W     head bundle PCA
//  CIA_out      out  DATA_W     head bundle CIA
//  count        out  ADDR_W+1   occupancy, 0..DEPTH
//  push_drop    out  1          1-cycle registered pulse: push rejected because full
// BEHAVIOUR
//  - Reset (RESET=0, takes effect immediately): wr_ptr=rd_ptr=0, count=0, empty=1,
//    full=0, push_drop=0, head outputs=0. The storage array is not reset.
//  - push_ok = pushReq & !full & !FLUSH. pop_ok = popReq & !empty & !FLUSH.
//    full and empty are the registered values from the start of the cycle.
//  - On push_ok: write the bundle at wr_ptr, then wr_ptr+1 (wraps mod DEPTH).
//  - On pop_ok: rd_ptr+1 (wraps mod DEPTH).
//  - count' = count + push_ok - pop_ok. full = (count==DEPTH). empty = (count==0).
//  - Full with push and pop in the same cycle: pop proceeds, push is rejected.
//    push_drop=1 next cycle. Fetch is expected to hold its bundle and retry.
//  - Empty with push and pop in the same cycle: pop is ignored and the push is accepted.
//    There is no bypass; the data appears on the outputs the next cycle.
//  - Latency: a bundle pushed at edge N is on the *_out ports after edge N and is poppable
//    in cycle N+1. Outputs are driven from the array at rd_ptr, gated to 0 while empty.
//  - FLUSH=1 at an edge: wr_ptr=rd_ptr=0 and count=0. It overrides a same-cycle push or
//    pop, so the offered bundle is discarded and push_drop is not raised.
//  - push_drop' = pushReq & full & !FLUSH. It is not sticky.
//  - pushReq or popReq while RESET=0 has no effect.
//  - Entries leave in strict FIFO order. Fields are never reordered or modified.
// STRUCTURE
//  - Shared pipeline package/header holds: the IFID entry width (4*DATA_W) and the field
//    bit offsets (INSTR1/INSTR2/PCA/CIA), plus the default DEPTH.
//  - Sub-module ifid_queue_ram: DEPTH x 4*DATA_W register array with one synchronous write
//    port and one asynchronous read port. It has no reset.
//  - Top level: pointers, count, flags, push_drop and output gating.
// TESTING
//  1. Reset: drop RESET mid-cycle with count=5 -> empty=1, count=0 and outputs=0
//     immediately, before the next CLK edge.
//  2. Fill: 8 pushes with Instr1=k, Instr2=k+100, PCA=4k, CIA=4k-4 (k=1..8) -> full=1 and
//     count=8. A 9th push -> push_drop=1 for 1 cycle and count stays 8.
//  3. Drain: 8 pops -> outputs Instr1=1..8 in order, empty=1 after the 8th, and outputs=0.
//  4. Steady state: at count=3, push+pop every cycle for 20 cycles -> count stays 3,
//     pointers wrap at least twice, and the output sequence equals the input sequence
//     delayed by 3.
//  5. Boundaries: push+pop at count=8 -> count=7 and push_drop=1. Push+pop at count=0 ->
//     count=1 and the head equals the pushed bundle on the next cycle.
//  6. Flush: FLUSH with pushReq=1 and popReq=1 at count=4 -> count=0 and empty=1 next
//     cycle, the pushed bundle never appears, and push_drop=0.

Source files
------------

// File: rtl/ifid_queue_pkg.sv
// ============================================================================
// Module   : ifid_queue_pkg
// Brief    : IFID entry geometry and default sizing for the fetch/decode queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ifid_queue_pkg;

  localparam int c_DATA_W     = 32;
  localparam int c_DEPTH      = 8;
  localparam int c_NUM_FIELDS = 4;
  localparam int c_ENTRY_W    = c_NUM_FIELDS * c_DATA_W;

  // Field order inside an entry, lowest bits first
  localparam int c_FLD_INSTR1 = 0;
  localparam int c_FLD_INSTR2 = 1;
  localparam int c_FLD_PCA    = 2;
  localparam int c_FLD_CIA    = 3;

  localparam int c_INSTR1_LSB = c_FLD_INSTR1 * c_DATA_W;
  localparam int c_INSTR2_LSB = c_FLD_INSTR2 * c_DATA_W;
  localparam int c_PCA_LSB    = c_FLD_PCA    * c_DATA_W;
  localparam int c_CIA_LSB    = c_FLD_CIA    * c_DATA_W;

  function automatic int field_lsb(input int idx, input int data_w);
    return idx * data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_queue_ram.sv
// ============================================================================
// Module   : ifid_queue_ram
// Brief    : Register array, one synchronous write port, one async read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifid_queue_ram #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 128
) (
  input  logic              CLK,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/ifid_queue.sv
// ============================================================================
// Module   : ifid_queue
// Brief    : First-word-fall-through bundle FIFO between fetch and decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int DEPTH  = c_DEPTH,
  parameter int ADDR_W = 3,
  parameter int DATA_W = c_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              pushReq,
  input  logic [DATA_W-1:0] Instr1_in,
  input  logic [DATA_W-1:0] Instr2_in,
  input  logic [DATA_W-1:0] PCA_in,
  input  logic [DATA_W-1:0] CIA_in,
  output logic              full,
  input  logic              popReq,
  output logic              empty,
  output logic [DATA_W-1:0] Instr1_out,
  output logic [DATA_W-1:0] Instr2_out,
  output logic [DATA_W-1:0] PCA_out,
  output logic [DATA_W-1:0] CIA_out,
  output logic [ADDR_W:0]   count,
  output logic              push_drop
);

  localparam int              c_ENTRY_W_P = c_NUM_FIELDS * DATA_W;
  localparam int              c_I1_LSB    = field_lsb(c_FLD_INSTR1, DATA_W);
  localparam int              c_I2_LSB    = field_lsb(c_FLD_INSTR2, DATA_W);
  localparam int              c_PCA_LSB_P = field_lsb(c_FLD_PCA, DATA_W);
  localparam int              c_CIA_LSB_P = field_lsb(c_FLD_CIA, DATA_W);
  localparam logic [ADDR_W:0] c_FULL_CNT  = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W:0]        r_count;
  logic                   r_full;
  logic                   r_empty;
  logic                   r_push_drop;
  logic                   w_push_ok;
  logic                   w_pop_ok;
  logic [ADDR_W:0]        w_count_nxt;
  logic [c_ENTRY_W_P-1:0] w_wdata;
  logic [c_ENTRY_W_P-1:0] w_rdata;

  assign w_push_ok = pushReq & ~r_full  & ~FLUSH;
  assign w_pop_ok  = popReq  & ~r_empty & ~FLUSH;

  always_comb begin
    w_count_nxt = r_count + (ADDR_W+1)'(w_push_ok) - (ADDR_W+1)'(w_pop_ok);
  end

  always_comb begin
    w_wdata = '0;
    w_wdata[c_I1_LSB    +: DATA_W] = Instr1_in;
    w_wdata[c_I2_LSB    +: DATA_W] = Instr2_in;
    w_wdata[c_PCA_LSB_P +: DATA_W] = PCA_in;
    w_wdata[c_CIA_LSB_P +: DATA_W] = CIA_in;
  end

  ifid_queue_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (c_ENTRY_W_P)
  ) u_ram (
    .CLK     (CLK),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_push_drop <= 1'b0;
    end else if (FLUSH) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_push_drop <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == c_FULL_CNT);
      r_empty     <= (w_count_nxt == '0);
      r_push_drop <= pushReq & r_full;
    end
  end

  // Head is gated so a stale array word never leaks out while empty
  assign Instr1_out = r_empty ? '0 : w_rdata[c_I1_LSB    +: DATA_W];
  assign Instr2_out = r_empty ? '0 : w_rdata[c_I2_LSB    +: DATA_W];
  assign PCA_out    = r_empty ? '0 : w_rdata[c_PCA_LSB_P +: DATA_W];
  assign CIA_out    = r_empty ? '0 : w_rdata[c_CIA_LSB_P +: DATA_W];

  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign push_drop = r_push_drop;

endmodule

`default_nettype wire
